// File: rtl/regs_file.sv
// regs_file
// Integer register file for the core: 32 architectural registers of 32 bits,
// one synchronous write port (writeback) and two combinational read ports
// (operand fetch). x0 has no storage and always reads zero. A same-cycle
// write-to-read bypass forwards wdata_i to any read port whose index matches
// the register being written.
//
// Ports:
//   clk       rising-edge clock for all state updates
//   rst_      asynchronous, active-high reset; clears x1..x31
//   we_i      write enable
//   waddr_i   write register index (writes to x0 are discarded)
//   wdata_i   write data
//   raddr1_i  read port 1 register index
//   raddr2_i  read port 2 register index
//   rdata1_o  read port 1 data (combinational)
//   rdata2_o  read port 2 data (combinational)
module regs_file (
  input  logic        clk,
  input  logic        rst_,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Only x1..x31 carry storage; x0 is synthesised as a constant zero.
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  // Register storage. Reset clears everything and takes priority over a
  // write presented in the same cycle.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  // Read port 1. Priority: x0, then bypass, then storage. The stored value is
  // masked while rst_ is high so the outputs show zero combinationally for
  // the whole reset interval, while the bypass path stays live.
  always_comb begin
    rdata1_o = '0;
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (we_i && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end else if (!rst_) begin
      rdata1_o = regs[raddr1_i];
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    rdata2_o = '0;
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (we_i && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end else if (!rst_) begin
      rdata2_o = regs[raddr2_i];
    end
  end

endmodule

// File: tb/tb_regs_file.sv
// tb_regs_file
// Self-checking bench for regs_file. Directed cases walk through reset,
// bypass, x0 discard, write-enable gating and a mid-cycle reset pulse, then
// a randomized phase compares both read ports against an array model of
// the architectural register state. Inputs change on the falling edge.
module tb_regs_file;

  logic        clk;
  logic        rst_;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr1_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata1_o;
  logic [31:0] rdata2_o;

  int compared = 0;
  int mismatched = 0;

  // Architectural register contents as seen after the most recent edge.
  logic [31:0] model [32];

  regs_file dut (
    .clk      (clk),
    .rst_     (rst_),
    .we_i     (we_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .rdata1_o (rdata1_o),
    .rdata2_o (rdata2_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] r1,
                               input logic [4:0] r2);
    we_i     = we;
    waddr_i  = wa;
    wdata_i  = wd;
    raddr1_i = r1;
    raddr2_i = r2;
  endtask

  // Value a read port must show for the current inputs and model state.
  function automatic logic [31:0] expRead(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (we_i && waddr_i == ra) return wdata_i;
    return model[ra];
  endfunction

  task automatic checkPorts(input string tag);
    checkOutput({tag, "_p1"}, rdata1_o, expRead(raddr1_i));
    checkOutput({tag, "_p2"}, rdata2_o, expRead(raddr2_i));
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance through a rising edge, committing the write the model sees.
  task automatic clockEdge();
    @(posedge clk);
    if (rst_) clearModel();
    else if (we_i && waddr_i != 5'd0) model[waddr_i] = wdata_i;
    @(negedge clk);
  endtask

  initial begin
    clearModel();
    rst_ = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state on both ports, including x0.
    #1;
    checkOutput("rst_x1_p1", rdata1_o, 32'h0);
    checkOutput("rst_x31_p2", rdata2_o, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    #1;
    checkOutput("rst_x31_p1", rdata1_o, 32'h0);
    checkOutput("rst_x1_p2", rdata2_o, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    checkOutput("rst_x0_p1", rdata1_o, 32'h0);
    rst_ = 1'b0;
    clockEdge();

    // Bypass before the edge, then stored value after it.
    applyStimulus(1'b1, 5'd1, 32'h42, 5'd1, 5'd0);
    #1;
    checkOutput("bypass_x1", rdata1_o, 32'h42);
    checkOutput("x0_p2", rdata2_o, 32'h0);
    clockEdge();
    applyStimulus(1'b0, 5'd1, 32'h0, 5'd1, 5'd0);
    #1;
    checkOutput("stored_x1", rdata1_o, 32'h42);
    checkOutput("x0_p2_after", rdata2_o, 32'h0);

    // Write x31, idle two cycles, read back alongside x1.
    applyStimulus(1'b1, 5'd31, 32'hDEADBEEF, 5'd0, 5'd0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    clockEdge();
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd31, 5'd1);
    #1;
    checkOutput("stored_x31", rdata1_o, 32'hDEADBEEF);
    checkOutput("still_x1", rdata2_o, 32'h42);

    // Writes to x0 are discarded, before and after the edge.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    checkOutput("x0_wr_pre_p1", rdata1_o, 32'h0);
    checkOutput("x0_wr_pre_p2", rdata2_o, 32'h0);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    checkOutput("x0_wr_post_p1", rdata1_o, 32'h0);
    checkOutput("x0_wr_post_p2", rdata2_o, 32'h0);

    // x5 on both ports; a disabled write must leave it alone.
    applyStimulus(1'b1, 5'd5, 32'h1234, 5'd5, 5'd5);
    #1;
    checkOutput("bypass_x5_p1", rdata1_o, 32'h1234);
    checkOutput("bypass_x5_p2", rdata2_o, 32'h1234);
    clockEdge();
    applyStimulus(1'b0, 5'd5, 32'hAAAA5555, 5'd5, 5'd5);
    #1;
    checkOutput("x5_we0_p1", rdata1_o, 32'h1234);
    checkOutput("x5_we0_p2", rdata2_o, 32'h1234);
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    checkOutput("x5_kept_p1", rdata1_o, 32'h1234);
    checkOutput("x5_kept_p2", rdata2_o, 32'h1234);

    // Mid-cycle reset pulse: x1/x31 drop to zero without a clock edge;
    // bypass still works during reset but the write is not committed.
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    checkOutput("pre_rst_x1", rdata1_o, 32'h42);
    checkOutput("pre_rst_x31", rdata2_o, 32'hDEADBEEF);
    rst_ = 1'b1;
    #1;
    checkOutput("midrst_x1", rdata1_o, 32'h0);
    checkOutput("midrst_x31", rdata2_o, 32'h0);
    applyStimulus(1'b1, 5'd3, 32'h5A5A5A5A, 5'd1, 5'd3);
    #1;
    checkOutput("midrst_bypass", rdata2_o, 32'h5A5A5A5A);
    clearModel();
    rst_ = 1'b0;
    we_i = 1'b0;
    clockEdge();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    #1;
    checkOutput("no_commit_x3", rdata1_o, 32'h0);
    checkOutput("postrst_x31", rdata2_o, 32'h0);

    // Randomized traffic against the model, with occasional reset pulses
    // and biased address matches to exercise the bypass.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] wa;
      logic [4:0] r1;
      logic [4:0] r2;
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, r1, r2);
      #1;
      checkPorts("rnd");
      if ($urandom_range(0, 63) == 0) begin
        #1;
        rst_ = 1'b1;
        clearModel();
        #1;
        checkPorts("rnd_rst");
        #1;
        rst_ = 1'b0;
      end
      clockEdge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
